// File: rtl/life_pkg.sv
// Shared types and helpers for the Game-of-Life round engine: FSM states,
// the 3x3 neighbour offset table and the B3/S23 rule.
package life_pkg;

    localparam int ADDR_W    = 24;
    localparam int NB_CENTRE = 4;

    // Per-cell phase: 0..8 issue neighbour reads, 9 takes the last sample, 10 writes.
    localparam logic [3:0] PH_LAST_READ = 4'd9;
    localparam logic [3:0] PH_WRITE     = 4'd10;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        READ,
        WRITE
    } state_t;

    typedef struct packed {
        logic signed [1:0] dr;
        logic signed [1:0] dc;
    } nb_off_t;

    function automatic nb_off_t nb_offset(input logic [3:0] k);
        nb_offset = '{dr: 2'sd0, dc: 2'sd0};
        case (k)
            4'd0: nb_offset = '{dr: -2'sd1, dc: -2'sd1};
            4'd1: nb_offset = '{dr: -2'sd1, dc:  2'sd0};
            4'd2: nb_offset = '{dr: -2'sd1, dc:  2'sd1};
            4'd3: nb_offset = '{dr:  2'sd0, dc: -2'sd1};
            4'd4: nb_offset = '{dr:  2'sd0, dc:  2'sd0};
            4'd5: nb_offset = '{dr:  2'sd0, dc:  2'sd1};
            4'd6: nb_offset = '{dr:  2'sd1, dc: -2'sd1};
            4'd7: nb_offset = '{dr:  2'sd1, dc:  2'sd0};
            4'd8: nb_offset = '{dr:  2'sd1, dc:  2'sd1};
            default: ;
        endcase
    endfunction

    function automatic logic next_state(input logic self, input logic [3:0] count);
        return (count == 4'd3) || (self && (count == 4'd2));
    endfunction

endpackage

// File: rtl/life_addr_gen.sv
// Row/column/phase counters for the generation sweep; produces the clamped
// neighbour read address, the in-grid mask for the pending sample and the write address.
module life_addr_gen
    import life_pkg::*;
#(
    parameter int P_M = 300,
    parameter int P_N = 400,
    parameter int P_W = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              step,
    output logic [3:0]        phase,
    output logic              last_cell,
    output logic              sample_in_grid,
    output logic [ADDR_W-1:0] read_pos,
    output logic [ADDR_W-1:0] write_pos
);

    localparam logic [P_W-1:0] ROW_MAX = P_W'(P_M - 1);
    localparam logic [P_W-1:0] COL_MAX = P_W'(P_N - 1);

    logic [P_W-1:0] row;
    logic [P_W-1:0] col;
    logic [P_W-1:0] row_n;
    logic [P_W-1:0] col_n;
    logic [3:0]     phase_n;

    function automatic logic signed [P_W+1:0] nb_coord(input logic [P_W-1:0] base,
                                                       input logic signed [1:0] off);
        return $signed({2'b00, base}) + off;
    endfunction

    function automatic logic [P_W-1:0] clamp(input logic signed [P_W+1:0] v,
                                             input logic [P_W-1:0] max_v);
        if (v < 0) return '0;
        if (v > $signed({2'b00, max_v})) return max_v;
        return v[P_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [P_W-1:0] r,
                                                    input logic [P_W-1:0] c);
        return ADDR_W'(r) * ADDR_W'(P_N) + ADDR_W'(c);
    endfunction

    // Edge neighbours are read from a clamped in-range address; the mask zeroes their sample.
    function automatic logic [ADDR_W-1:0] nb_addr(input logic [P_W-1:0] r,
                                                  input logic [P_W-1:0] c,
                                                  input logic [3:0] k);
        nb_off_t nb;
        nb = nb_offset(k);
        return cell_addr(clamp(nb_coord(r, nb.dr), ROW_MAX), clamp(nb_coord(c, nb.dc), COL_MAX));
    endfunction

    function automatic logic in_grid(input logic [P_W-1:0] r,
                                     input logic [P_W-1:0] c,
                                     input logic [3:0] k);
        nb_off_t                nb;
        logic signed [P_W+1:0]  rs;
        logic signed [P_W+1:0]  cs;
        nb = nb_offset(k);
        rs = nb_coord(r, nb.dr);
        cs = nb_coord(c, nb.dc);
        return (rs >= 0) && (rs <= $signed({2'b00, ROW_MAX})) &&
               (cs >= 0) && (cs <= $signed({2'b00, COL_MAX}));
    endfunction

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        row_n   = row;
        col_n   = col;
        phase_n = phase;
        if (clear) begin
            row_n   = '0;
            col_n   = '0;
            phase_n = '0;
        end else if (step) begin
            if (phase == PH_WRITE) begin
                phase_n = '0;
                if (col == COL_MAX) begin
                    col_n = '0;
                    row_n = (row == ROW_MAX) ? '0 : row + P_W'(1);
                end else begin
                    col_n = col + P_W'(1);
                end
            end else begin
                phase_n = phase + 4'd1;
            end
        end
    end

    assign last_cell      = (row == ROW_MAX) && (col == COL_MAX);
    assign sample_in_grid = in_grid(row, col, phase - 4'd1);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row       <= '0;
            col       <= '0;
            phase     <= '0;
            read_pos  <= '0;
            write_pos <= '0;
        end else begin
            row       <= row_n;
            col       <= col_n;
            phase     <= phase_n;
            read_pos  <= nb_addr(row_n, col_n, phase_n);
            write_pos <= cell_addr(row_n, col_n);
        end
    end

endmodule

// File: rtl/life_round_engine.sv
// Game-of-Life generation engine: one full-grid B3/S23 sweep per evolution
// edge, 11 cycles per cell, reading the source RAM and writing the destination RAM.
module life_round_engine
    import life_pkg::*;
#(
    parameter int P_M = 300,
    parameter int P_N = 400,
    parameter int P_W = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              global_evo_en,
    input  logic              prev_status,
    output logic              wden,
    output logic [ADDR_W-1:0] round_read_pos,
    output logic [ADDR_W-1:0] round_write_pos,
    output logic              live
);

    state_t     state;
    state_t     state_n;
    logic       edge_q;
    logic       edge_n;
    logic [3:0] count;
    logic [3:0] count_n;
    logic       self_q;
    logic       self_n;
    logic       wden_n;
    logic       live_n;
    logic       clear;
    logic       step;
    logic [3:0] phase;
    logic       last_cell;
    logic       sample_in_grid;
    logic       sample;

    life_addr_gen #(
        .P_M (P_M),
        .P_N (P_N),
        .P_W (P_W)
    ) u_addr_gen (
        .clk            (clk),
        .reset_n        (reset_n),
        .clear          (clear),
        .step           (step),
        .phase          (phase),
        .last_cell      (last_cell),
        .sample_in_grid (sample_in_grid),
        .read_pos       (round_read_pos),
        .write_pos      (round_write_pos)
    );

    assign sample = prev_status & sample_in_grid;

    always_comb begin
        state_n = state;
        edge_n  = edge_q;
        count_n = count;
        self_n  = self_q;
        wden_n  = 1'b0;
        live_n  = 1'b0;
        clear   = 1'b0;
        step    = 1'b0;
        case (state)
            IDLE: ;
            ARMED: begin
                if (global_evo_en != edge_q) begin
                    edge_n  = global_evo_en;
                    clear   = 1'b1;
                    count_n = '0;
                    self_n  = 1'b0;
                    state_n = READ;
                end
            end
            READ: begin
                // Edges arriving mid-pass are absorbed, not queued.
                edge_n = global_evo_en;
                step   = 1'b1;
                if (phase != 4'd0) begin
                    if (phase == 4'(NB_CENTRE + 1)) self_n  = sample;
                    else                            count_n = count + {3'b000, sample};
                end
                if (phase == PH_LAST_READ) begin
                    state_n = WRITE;
                    wden_n  = 1'b1;
                    live_n  = next_state(self_n, count_n);
                end
            end
            WRITE: begin
                edge_n  = global_evo_en;
                step    = 1'b1;
                count_n = '0;
                self_n  = 1'b0;
                state_n = last_cell ? ARMED : READ;
            end
            default: state_n = IDLE;
        endcase
        if (start) begin
            state_n = ARMED;
            edge_n  = global_evo_en;
            wden_n  = 1'b0;
            live_n  = 1'b0;
            clear   = 1'b0;
            step    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            edge_q <= 1'b0;
            count  <= '0;
            self_q <= 1'b0;
            wden   <= 1'b0;
            live   <= 1'b0;
        end else begin
            state  <= state_n;
            edge_q <= edge_n;
            count  <= count_n;
            self_q <= self_n;
            wden   <= wden_n;
            live   <= live_n;
        end
    end

endmodule

// File: tb/tb_life_round_engine.sv
// Self-checking bench for life_round_engine on an 8x8 grid with a behavioural
// 1-cycle-latency source RAM and a neighbour-counting reference model.
module tb_life_round_engine;

    localparam int M = 8;
    localparam int N = 8;
    localparam int CELLS = M * N;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        global_evo_en = 1'b0;
    logic        prev_status = 1'b0;
    logic        wden;
    logic        live;
    logic [23:0] round_read_pos;
    logic [23:0] round_write_pos;

    bit src_mem [CELLS];
    bit exp_grid [CELLS];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int oob_n = 0;
    int wr_addr [$];
    bit wr_live [$];
    int wr_cyc [$];

    life_round_engine #(
        .P_M (M),
        .P_N (N),
        .P_W (12)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .global_evo_en   (global_evo_en),
        .prev_status     (prev_status),
        .wden            (wden),
        .round_read_pos  (round_read_pos),
        .round_write_pos (round_write_pos),
        .live            (live)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) prev_status <= src_mem[round_read_pos[5:0]];

    always @(negedge clk) begin
        if (wden === 1'b1) begin
            wr_addr.push_back(int'(round_write_pos));
            wr_live.push_back(live);
            wr_cyc.push_back(cyc);
        end
        if (round_read_pos >= 24'(CELLS)) oob_n++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        @(posedge clk);
        wr_addr.delete();
        wr_live.delete();
        wr_cyc.delete();
        oob_n = 0;
    endtask

    task automatic clear_grids();
        for (int i = 0; i < CELLS; i++) begin
            src_mem[i]  = 1'b0;
            exp_grid[i] = 1'b0;
        end
    endtask

    // Reference: count in-bounds live neighbours directly, no wrap-around.
    task automatic model_next();
        for (int r = 0; r < M; r++) begin
            for (int c = 0; c < N; c++) begin
                int n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr = r + dr;
                        int cc = c + dc;
                        if ((dr != 0 || dc != 0) && rr >= 0 && rr < M && cc >= 0 && cc < N)
                            n += int'(src_mem[rr * N + cc]);
                    end
                end
                exp_grid[r * N + c] = (n == 3) || (src_mem[r * N + c] && n == 2);
            end
        end
    endtask

    task automatic randomize_src();
        for (int i = 0; i < CELLS; i++) src_mem[i] = ($urandom_range(0, 99) < 40);
        model_next();
    endtask

    task automatic run_pass(input string tag, input bit arm, input int mid_toggle);
        int t0;
        int lat;
        int spacing_bad;
        int order_bad;
        int cell_bad;
        int first_bad;
        bit got [CELLS];
        spacing_bad = 0;
        order_bad   = 0;
        cell_bad    = 0;
        first_bad   = -1;
        for (int i = 0; i < CELLS; i++) got[i] = 1'b0;
        clear_log();
        if (arm) begin
            @(negedge clk) start = 1'b1;
            @(negedge clk) start = 1'b0;
        end
        repeat (2) @(negedge clk);
        t0 = cyc;
        global_evo_en = ~global_evo_en;
        for (int i = 1; i <= 760; i++) begin
            @(negedge clk);
            if (i == mid_toggle) global_evo_en = ~global_evo_en;
        end

        checks++;
        if (wr_addr.size() != CELLS) begin
            errors++;
            $display("FAIL %s_write_count: got %0d expected %0d", tag, wr_addr.size(), CELLS);
        end

        lat = (wr_cyc.size() > 0) ? wr_cyc[0] - t0 : -1;
        checks++;
        if (lat != 11) begin
            errors++;
            $display("FAIL %s_first_latency: got %0d expected 11", tag, lat);
        end

        for (int i = 1; i < wr_cyc.size(); i++)
            if (wr_cyc[i] - wr_cyc[i-1] != 11) spacing_bad++;
        for (int i = 0; i < wr_addr.size(); i++) begin
            if (wr_addr[i] != i) order_bad++;
            if (wr_addr[i] >= 0 && wr_addr[i] < CELLS) got[wr_addr[i]] = wr_live[i];
        end
        for (int i = 0; i < CELLS; i++) begin
            if (got[i] != exp_grid[i]) begin
                cell_bad++;
                if (first_bad < 0) first_bad = i;
            end
        end

        checks++;
        if (spacing_bad != 0) begin
            errors++;
            $display("FAIL %s_spacing: got %0d gaps not 11 cycles, expected 0", tag, spacing_bad);
        end
        checks++;
        if (order_bad != 0) begin
            errors++;
            $display("FAIL %s_write_order: got %0d out-of-order addresses, expected 0", tag, order_bad);
        end
        checks++;
        if (cell_bad != 0) begin
            errors++;
            $display("FAIL %s_cells: got %0d wrong cells (first at %0d: got %0d expected %0d), expected 0",
                     tag, cell_bad, first_bad, got[first_bad], exp_grid[first_bad]);
        end
        checks++;
        if (oob_n != 0) begin
            errors++;
            $display("FAIL %s_read_range: got %0d out-of-range read cycles, expected 0", tag, oob_n);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (wden !== 1'b0) begin
            errors++;
            $display("FAIL reset_wden: got %b expected 0", wden);
        end
        checks++;
        if (live !== 1'b0) begin
            errors++;
            $display("FAIL reset_live: got %b expected 0", live);
        end
        checks++;
        if (round_read_pos !== 24'd0) begin
            errors++;
            $display("FAIL reset_read_pos: got %0d expected 0", round_read_pos);
        end
        checks++;
        if (round_write_pos !== 24'd0) begin
            errors++;
            $display("FAIL reset_write_pos: got %0d expected 0", round_write_pos);
        end
    endtask

    task automatic test_no_start();
        clear_log();
        for (int i = 0; i < 3; i++) begin
            repeat (30) @(negedge clk);
            global_evo_en = ~global_evo_en;
        end
        repeat (60) @(negedge clk);
        checks++;
        if (wr_addr.size() != 0) begin
            errors++;
            $display("FAIL no_start_writes: got %0d expected 0", wr_addr.size());
        end
    endtask

    task automatic test_blinker();
        clear_grids();
        src_mem[3*N + 4] = 1'b1;
        src_mem[4*N + 4] = 1'b1;
        src_mem[5*N + 4] = 1'b1;
        exp_grid[4*N + 3] = 1'b1;
        exp_grid[4*N + 4] = 1'b1;
        exp_grid[4*N + 5] = 1'b1;
        run_pass("blinker", 1'b1, 0);
    endtask

    task automatic test_block_corner();
        clear_grids();
        src_mem[0]     = 1'b1;
        src_mem[1]     = 1'b1;
        src_mem[N]     = 1'b1;
        src_mem[N + 1] = 1'b1;
        exp_grid[0]     = 1'b1;
        exp_grid[1]     = 1'b1;
        exp_grid[N]     = 1'b1;
        exp_grid[N + 1] = 1'b1;
        run_pass("block", 1'b0, 0);
    endtask

    task automatic test_no_wrap();
        clear_grids();
        src_mem[0]         = 1'b1;
        src_mem[CELLS - 1] = 1'b1;
        run_pass("no_wrap", 1'b0, 0);
    endtask

    task automatic test_full_grid();
        clear_grids();
        for (int i = 0; i < CELLS; i++) src_mem[i] = 1'b1;
        exp_grid[0]         = 1'b1;
        exp_grid[N - 1]     = 1'b1;
        exp_grid[CELLS - N] = 1'b1;
        exp_grid[CELLS - 1] = 1'b1;
        run_pass("full", 1'b0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            randomize_src();
            run_pass("random", 1'b0, 0);
        end
    endtask

    task automatic test_evo_mid_pass();
        randomize_src();
        run_pass("evo_mid", 1'b0, 100);
        clear_log();
        repeat (200) @(negedge clk);
        checks++;
        if (wr_addr.size() != 0) begin
            errors++;
            $display("FAIL evo_mid_no_second_pass: got %0d writes expected 0", wr_addr.size());
        end
    endtask

    task automatic test_start_abort();
        randomize_src();
        @(negedge clk) global_evo_en = ~global_evo_en;
        repeat (150) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        clear_log();
        repeat (100) @(negedge clk);
        checks++;
        if (wr_addr.size() != 0) begin
            errors++;
            $display("FAIL abort_writes: got %0d expected 0", wr_addr.size());
        end
        run_pass("after_abort", 1'b0, 0);
    endtask

    task automatic test_reset_mid_pass();
        bit reached;
        reached = 1'b0;
        randomize_src();
        clear_log();
        @(negedge clk) global_evo_en = ~global_evo_en;
        for (int i = 0; i < 400 && !reached; i++) begin
            @(negedge clk);
            #1;
            if (wr_addr.size() >= 21) reached = 1'b1;
        end
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL reset_mid_reach_cell20: got %0d writes expected 21", wr_addr.size());
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (wden !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_wden: got %b expected 0", wden);
        end
        checks++;
        if (live !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_live: got %b expected 0", live);
        end
        checks++;
        if (round_read_pos !== 24'd0) begin
            errors++;
            $display("FAIL reset_mid_read_pos: got %0d expected 0", round_read_pos);
        end
        checks++;
        if (round_write_pos !== 24'd0) begin
            errors++;
            $display("FAIL reset_mid_write_pos: got %0d expected 0", round_write_pos);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        clear_log();
        repeat (5) @(negedge clk);
        global_evo_en = ~global_evo_en;
        repeat (200) @(negedge clk);
        checks++;
        if (wr_addr.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_idle_after: got %0d writes expected 0", wr_addr.size());
        end
    endtask

    initial begin
        test_reset();
        test_no_start();
        test_blinker();
        test_block_corner();
        test_no_wrap();
        test_full_grid();
        test_random();
        test_evo_mid_pass();
        test_start_abort();
        test_reset_mid_pass();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
